// File: rtl/rr_mux_slice_if.sv
// Handshake bundle for rr_mux_slice: N source channels in, one registered slice out.
// RR_MUX_LOCK_EN adds the per-channel lock_i burst request.
interface rr_mux_slice_if #(
    parameter int unsigned size  = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
);
    logic [N*size-1:0] data_i;
    logic [N-1:0]      valid_i;
    logic [N-1:0]      ready_o;
    logic              mode_i;
    logic [size-1:0]   data_o;
    logic              valid_o;
    logic              ready_i;
    logic [SEL_W-1:0]  grant_o;
`ifdef RR_MUX_LOCK_EN
    logic [N-1:0]      lock_i;
`endif

    modport master (
`ifdef RR_MUX_LOCK_EN
        output lock_i,
`endif
        output data_i, valid_i, mode_i, ready_i,
        input  ready_o, data_o, valid_o, grant_o
    );

    modport slave (
`ifdef RR_MUX_LOCK_EN
        input  lock_i,
`endif
        input  data_i, valid_i, mode_i, ready_i,
        output ready_o, data_o, valid_o, grant_o
    );
endinterface

// File: rtl/rr_mux_slice.sv
// N-input round-robin / fixed-priority selector feeding a one-entry registered output slice.
// Optional burst lock on the held channel is enabled with `define RR_MUX_LOCK_EN.
module rr_mux_slice #(
    parameter int unsigned size  = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    rr_mux_slice_if.slave bus
);

    generate
        if (size < 1 || N < 2 || N > 16 || SEL_W != $clog2(N)) begin : g_param_check
            $error("rr_mux_slice: illegal parameters size=%0d N=%0d SEL_W=%0d", size, N, SEL_W);
        end
    endgenerate

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, grant_q, win_idx, ptr_next;
    logic [size-1:0]   data_q, win_data;
    logic [N-1:0]      grant_mask, eff_valid, rot_valid, ready_vec;
    logic              win_found, can_load, accept, lock_active;
    int unsigned       base, pos, pos_inc;

`ifdef RR_MUX_LOCK_EN
    always_comb lock_active = (state_q == FULL) && bus.lock_i[grant_q];
`else
    always_comb lock_active = 1'b0;
`endif

    // Rotate the request vector so the search always starts at bit 0, then map back.
    always_comb begin
        grant_mask = '0;
        for (int unsigned k = 0; k < N; k++) begin
            grant_mask[k] = (SEL_W'(k) == grant_q);
        end
        eff_valid = lock_active ? (bus.valid_i & grant_mask) : bus.valid_i;
        base      = bus.mode_i ? 0 : 32'(ptr_q);
        rot_valid = bus.mode_i ? eff_valid : N'({eff_valid, eff_valid} >> ptr_q);

        win_found = 1'b0;
        pos       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!win_found && rot_valid[i]) begin
                win_found = 1'b1;
                pos       = i + base;
            end
        end
        if (pos >= N) pos = pos - N;
        win_idx = SEL_W'(pos);

        pos_inc = pos + 1;
        if (pos_inc >= N) pos_inc = 0;
        ptr_next = SEL_W'(pos_inc);

        win_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (SEL_W'(k) == win_idx) win_data = bus.data_i[k*size +: size];
        end
    end

    always_comb begin
        can_load = (state_q == EMPTY) || bus.ready_i;
        accept   = can_load && win_found;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (!accept && bus.ready_i) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // ready_o is gated by rst_i so sources never see a grant while reset is held.
    always_comb begin
        ready_vec = '0;
        if (rst_i && accept) ready_vec[win_idx] = 1'b1;
        bus.ready_o = ready_vec;
        bus.valid_o = (state_q == FULL);
        bus.data_o  = data_q;
        bus.grant_o = grant_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q  <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else if (accept) begin
            data_q  <= win_data;
            grant_q <= win_idx;
            if (!bus.mode_i && !lock_active) ptr_q <= ptr_next;
        end
    end

endmodule

// File: tb/tb_rr_mux_slice.sv
// Directed bench for rr_mux_slice: N=4 and N=3 instances, lock scenario under RR_MUX_LOCK_EN.
module tb_rr_mux_slice;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rr_mux_slice_if #(.size(32), .N(4), .SEL_W(2)) b4 ();
    rr_mux_slice_if #(.size(32), .N(3), .SEL_W(2)) b3 ();

    rr_mux_slice #(.size(32), .N(4), .SEL_W(2)) dut4 (.clk_i(clk), .rst_i(rst), .bus(b4.slave));
    rr_mux_slice #(.size(32), .N(3), .SEL_W(2)) dut3 (.clk_i(clk), .rst_i(rst), .bus(b3.slave));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        b4.valid_i = '0; b4.ready_i = 1'b1; b4.mode_i = 1'b0;
        b3.valid_i = '0; b3.ready_i = 1'b1; b3.mode_i = 1'b0;
`ifdef RR_MUX_LOCK_EN
        b4.lock_i = '0;
        b3.lock_i = '0;
`endif
        for (int k = 0; k < 4; k++) b4.data_i[k*32 +: 32] = 32'hA0 + 32'(k);
        for (int k = 0; k < 3; k++) b3.data_i[k*32 +: 32] = 32'hB0 + 32'(k);
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        b4.valid_i = 4'b1111;
        #2;
        checks++; if (b4.valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", b4.valid_o); end
        checks++; if (b4.data_o !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", b4.data_o); end
        checks++; if (b4.grant_o !== 2'd0) begin failures++; $display("FAIL rst_grant got=%0d exp=0", b4.grant_o); end
        checks++; if (b4.ready_o !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", b4.ready_o); end
        cyc();
        rst = 1'b1;
        #1;
        checks++; if (b4.ready_o !== 4'b0001) begin failures++; $display("FAIL rst_first_ready got=%b exp=0001", b4.ready_o); end
        cyc();
        checks++; if (b4.data_o !== 32'hA0) begin failures++; $display("FAIL rst_first_data got=%h exp=a0", b4.data_o); end
        cyc();
        checks++; if (b4.grant_o !== 2'd1) begin failures++; $display("FAIL rst_second_grant got=%0d exp=1", b4.grant_o); end
        // Asynchronous reset in the middle of a transfer
        #3;
        rst = 1'b0;
        #1;
        checks++; if (b4.valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", b4.valid_o); end
        checks++; if (b4.data_o !== 32'h0) begin failures++; $display("FAIL midrst_data got=%h exp=0", b4.data_o); end
        checks++; if (b4.grant_o !== 2'd0) begin failures++; $display("FAIL midrst_grant got=%0d exp=0", b4.grant_o); end
        checks++; if (b4.ready_o !== 4'b0000) begin failures++; $display("FAIL midrst_ready got=%b exp=0000", b4.ready_o); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (b4.ready_o !== 4'b0001) begin failures++; $display("FAIL midrst_after_ready got=%b exp=0001", b4.ready_o); end
        cyc();
        checks++; if (b4.grant_o !== 2'd0 || b4.data_o !== 32'hA0) begin failures++; $display("FAIL midrst_after_grant got=%0d/%h exp=0/a0", b4.grant_o, b4.data_o); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [31:0] exp_dat [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
        do_reset();
        b4.valid_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (b4.ready_o !== exp_rdy[i]) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, b4.ready_o, exp_rdy[i]); end
            cyc();
            checks++; if (b4.valid_o !== 1'b1 || b4.data_o !== exp_dat[i]) begin failures++; $display("FAIL rr_data[%0d] got=%b/%h exp=1/%h", i, b4.valid_o, b4.data_o, exp_dat[i]); end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        b4.mode_i  = 1'b1;
        b4.valid_i = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (b4.ready_o !== 4'b0010) begin failures++; $display("FAIL fp_ready[%0d] got=%b exp=0010", i, b4.ready_o); end
            cyc();
            checks++; if (b4.grant_o !== 2'd1 || b4.data_o !== 32'hA1) begin failures++; $display("FAIL fp_grant[%0d] got=%0d/%h exp=1/a1", i, b4.grant_o, b4.data_o); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        b4.data_i[64 +: 32] = 32'hDEAD;
        b4.valid_i = 4'b0100;
        #1;
        checks++; if (b4.ready_o !== 4'b0100) begin failures++; $display("FAIL bp_load_ready got=%b exp=0100", b4.ready_o); end
        cyc();
        checks++; if (b4.data_o !== 32'hDEAD || b4.grant_o !== 2'd2) begin failures++; $display("FAIL bp_load got=%h/%0d exp=dead/2", b4.data_o, b4.grant_o); end
        b4.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (b4.ready_o !== 4'b0000) begin failures++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0000", i, b4.ready_o); end
            cyc();
            checks++; if (b4.valid_o !== 1'b1 || b4.data_o !== 32'hDEAD || b4.grant_o !== 2'd2) begin failures++; $display("FAIL bp_stall_hold[%0d] got=%b/%h/%0d exp=1/dead/2", i, b4.valid_o, b4.data_o, b4.grant_o); end
        end
        b4.ready_i = 1'b1;
        b4.valid_i = 4'b0000;
        #1;
        checks++; if (b4.ready_o !== 4'b0000) begin failures++; $display("FAIL bp_drain_ready got=%b exp=0000", b4.ready_o); end
        cyc();
        checks++; if (b4.valid_o !== 1'b0 || b4.data_o !== 32'hDEAD || b4.grant_o !== 2'd2) begin failures++; $display("FAIL bp_drain got=%b/%h/%0d exp=0/dead/2", b4.valid_o, b4.data_o, b4.grant_o); end
    endtask

    task automatic test_wrap_sparse();
        do_reset();
        b4.valid_i = 4'b0100;
        cyc();
        b4.valid_i = 4'b0001;
        #1;
        checks++; if (b4.ready_o !== 4'b0001) begin failures++; $display("FAIL wrap_ready got=%b exp=0001", b4.ready_o); end
        cyc();
        checks++; if (b4.grant_o !== 2'd0) begin failures++; $display("FAIL wrap_grant got=%0d exp=0", b4.grant_o); end
        b4.valid_i = 4'b0011;
        #1;
        checks++; if (b4.ready_o !== 4'b0010) begin failures++; $display("FAIL wrap_ptr_ready got=%b exp=0010", b4.ready_o); end
        cyc();
        checks++; if (b4.grant_o !== 2'd1 || b4.data_o !== 32'hA1) begin failures++; $display("FAIL wrap_ptr_grant got=%0d/%h exp=1/a1", b4.grant_o, b4.data_o); end
        b4.valid_i = 4'b0000;
        #1;
        checks++; if (b4.ready_o !== 4'b0000) begin failures++; $display("FAIL idle_ready got=%b exp=0000", b4.ready_o); end
        cyc();
        checks++; if (b4.valid_o !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", b4.valid_o); end
    endtask

    task automatic test_mode_switch();
        do_reset();
        b4.valid_i = 4'b1111;
        cyc();
        b4.mode_i = 1'b1;
        cyc();
        checks++; if (b4.grant_o !== 2'd0) begin failures++; $display("FAIL mode_fp_grant0 got=%0d exp=0", b4.grant_o); end
        cyc();
        checks++; if (b4.grant_o !== 2'd0) begin failures++; $display("FAIL mode_fp_grant1 got=%0d exp=0", b4.grant_o); end
        b4.mode_i = 1'b0;
        cyc();
        checks++; if (b4.grant_o !== 2'd1) begin failures++; $display("FAIL mode_rr_resume got=%0d exp=1", b4.grant_o); end
    endtask

    task automatic test_n3();
        logic [2:0] exp_rdy [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [1:0] exp_gnt [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [31:0] exp_dat [4] = '{32'hB0, 32'hB1, 32'hB2, 32'hB0};
        do_reset();
        b3.valid_i = 3'b111;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (b3.ready_o !== exp_rdy[i]) begin failures++; $display("FAIL n3_ready[%0d] got=%b exp=%b", i, b3.ready_o, exp_rdy[i]); end
            cyc();
            checks++; if (b3.grant_o !== exp_gnt[i] || b3.data_o !== exp_dat[i]) begin failures++; $display("FAIL n3_grant[%0d] got=%0d/%h exp=%0d/%h", i, b3.grant_o, b3.data_o, exp_gnt[i], exp_dat[i]); end
        end
    endtask

`ifdef RR_MUX_LOCK_EN
    task automatic test_lock();
        do_reset();
        b4.valid_i = 4'b1111;
        cyc();
        cyc();
        b4.lock_i = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (b4.ready_o !== 4'b0100) begin failures++; $display("FAIL lock_ready[%0d] got=%b exp=0100", i, b4.ready_o); end
            cyc();
            checks++; if (b4.grant_o !== 2'd2 || b4.data_o !== 32'hA2) begin failures++; $display("FAIL lock_grant[%0d] got=%0d/%h exp=2/a2", i, b4.grant_o, b4.data_o); end
        end
        b4.lock_i = 4'b0000;
        #1;
        checks++; if (b4.ready_o !== 4'b1000) begin failures++; $display("FAIL unlock_ready got=%b exp=1000", b4.ready_o); end
        cyc();
        checks++; if (b4.grant_o !== 2'd3) begin failures++; $display("FAIL unlock_grant got=%0d exp=3", b4.grant_o); end
    endtask
`endif

    initial begin
        rst = 1'b0;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_wrap_sparse();
        test_mode_switch();
        test_n3();
`ifdef RR_MUX_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux_slice.md
Name: rr_mux_slice

Overview:
- Parametrised N-input datapath selector for the pipelined CPU: successor to the fixed 3:1 select mux.
- Arbitrates among N valid/ready source channels in round-robin or fixed-priority mode.
- Registers the winner into a one-entry output slice with a valid/ready handshake toward the consumer stage.
- Serves shared write-back, forwarding and memory-request paths where more than one producer competes.

Parameters:
- size, 32, data width per channel in bits (must be >= 1).
- N, 4, number of input channels (2..16).
- SEL_W, 2, grant index width; must equal ceil(log2(N)), checked by elaboration assertion.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- data_i  input  N*size  channel k occupies bits [k*size +: size].
- valid_i  input  N  channel k has data.
- ready_o  output  N  channel k accepted this cycle (one-hot or zero).
- mode_i  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- data_o  output  size  registered selected data.
- valid_o  output  1  data_o valid.
- ready_i  input  1  consumer accepts data_o.
- grant_o  output  SEL_W  index of channel held in the slice.

Behaviour:
- Reset (rst_i low, async): valid_o=0, data_o=0, grant_o=0, round-robin pointer ptr=0; ready_o=0 while in reset.
- Slice has two states.
  - EMPTY: valid_o=0.
  - FULL: valid_o=1.
- can_load = !valid_o | ready_i.
- Arbitration (combinational, same cycle):
  - Round-robin: search valid_i starting at index ptr, ascending, wrapping N-1 -> 0; first set bit wins.
  - Fixed priority: lowest set index wins; ptr is ignored and left unchanged.
- ready_o[w]=1 only if can_load and valid_i[w] and w is the winner; all other bits 0.
- ready_o must never depend on a valid_i bit other than through the winner selection.
- Accept (rising edge with can_load and any valid_i):
  - data_o <= winner data; grant_o <= w; valid_o <= 1.
  - Round-robin only: ptr <= (w+1) mod N, wrapping at N-1 -> 0, including non-power-of-two N.
- Consumer takes data (valid_o & ready_i) with no valid_i: valid_o <= 0; data_o and grant_o hold their last values.
- Simultaneous consume and accept: new data loads in the same edge; no bubble. Full throughput is 1 transfer per cycle.
- Stall (valid_o & !ready_i):
  - ready_o = 0.
  - data_o, grant_o and ptr stable.
  - Sources must hold valid_i/data_i (AXI-style rule; the bench checks data_o stability only).
- Latency: source accept to valid_o = 1 cycle.
- mode_i change takes effect at the next arbitration; ptr is retained across mode changes.
- Reset asserted mid-transfer: slice is flushed and the held data is lost. Sources see no ready_o during reset.
- No valid_i in any mode: ready_o=0, ptr unchanged.

Optional Feature:
- Macro: RR_MUX_LOCK_EN.
- With the macro defined:
  - Extra input lock_i [N].
  - If the slice holds grant g and lock_i[g]=1, arbitration is restricted to channel g only. Other channels get ready_o=0 even if valid_i is set; the burst continues until channel g drops lock_i[g].
  - ptr does not advance while locked.
  - On the accept where lock_i[g]=0, normal pointer update applies.
  - Reset clears the lock condition (valid_o=0).
- Without the macro: no lock_i port; behaviour exactly as above.

Test Plan:
- Reset: rst_i=0 mid-run with valid_i=4'b1111 -> valid_o=0, data_o=0, grant_o=0, ready_o=0 immediately (async). After release, first grant is ch0.
- Round-robin fairness:
  - N=4, mode_i=0, valid_i=4'b1111 constant, ready_i=1, data_i ch k = 32'hA0+k.
  - data_o sequence A0,A1,A2,A3,A0, one per cycle, with no bubbles.
- Fixed priority: mode_i=1, valid_i=4'b1010 -> always grants ch1 (grant_o=1), ready_o=4'b0010 every cycle; ch3 starves.
- Backpressure:
  - Load ch2 = 32'hDEAD, then ready_i=0 for 5 cycles.
  - data_o=32'hDEAD and valid_o=1 stable; ready_o=0.
  - Then ready_i=1 with valid_i=0 -> valid_o drops next cycle.
- Wrap and sparse:
  - ptr=3, valid_i=4'b0001 -> ch0 granted, ptr becomes 1.
  - With N=3: grants cycle 0,1,2,0 with no illegal index.
- Lock (RR_MUX_LOCK_EN):
  - ch2 lock_i=1 for 3 beats while valid_i=4'b1111 -> grant_o=2 for 3 consecutive transfers.
  - Lock drops -> next grant is ch3.
